dsp_sample_feeder: RTL
======================

Name: dsp_sample_feeder

Overview:
- Paced input stage that sits directly upstream of the 4-tap moving-average filter.
- Accepts 32-bit samples from the host side over a valid/ready handshake and buffers them in a small FIFO.
- Presents buffered samples to the filter one at a time on sample_out, each with a single-cycle dsp_control = 5'b00001 shift strobe.
- Strobes are spaced by a programmable interval, so the filter advances at a controlled rate.

Parameters:
- DEPTH, 4: FIFO depth in words. Must be a power of 2, minimum 2.
- AW, 2: FIFO address width, log2(DEPTH).
- DW, 32: sample width.

Ports:
- clk  input  1  Rising-edge clock.
- reset  input  1  Asynchronous, active-low reset. Asserted when 0.
- flush  input  1  Synchronous clear of the FIFO and the pacing state.
- enable  input  1  Allows issuing samples to the filter.
- interval  input  8  Idle cycles inserted after each strobe. Sampled at the moment of issue.
- in_valid  input  1  Upstream sample present.
- in_data  input  DW  Upstream sample.
- in_ready  output  1  FIFO can accept a word.
- sample_out  output  DW  Sample to the filter's sample_in. Registered.
- dsp_control  output  5  Filter control. 5'b00001 for exactly one cycle per issued sample, otherwise 5'b00000. Registered.
- fifo_level  output  AW+1  Current FIFO occupancy, 0..DEPTH.
- busy  output  1  High when the FSM is in WAIT or the FIFO is non-empty.

Behaviour:
- Reset (reset = 0, asynchronous):
  - FIFO pointers and level go to 0.
  - FSM goes to IDLE and pace_cnt to 0.
  - sample_out = 0, dsp_control = 0, busy = 0, in_ready = 1.
  - The same values hold for a reset asserted mid-operation; any in-flight strobe is cancelled.
- Push:
  - in_ready = (fifo_level != DEPTH), derived combinationally from registered state.
  - A word is written on a clk edge where in_valid && in_ready && !flush.
  - Writes at the tail; the write pointer wraps modulo DEPTH.
- Pop: happens only on an issue (see FSM). Reads the head; the read pointer wraps modulo DEPTH.
- Simultaneous push and pop: both occur and fifo_level is unchanged. Not possible when full, because in_ready = 0.
- FSM states:
  - IDLE:
    - If enable && fifo_level != 0: pop the head, register sample_out <= head and dsp_control <= 5'b00001, load pace_cnt <= interval, go to WAIT.
    - Otherwise dsp_control <= 0.
  - WAIT:
    - dsp_control <= 0.
    - If pace_cnt == 0, go to IDLE; else pace_cnt decrements by 1.
- Timing and rate:
  - Strobe spacing is interval + 2 cycles. With interval = 0 there is one strobe every 2nd cycle.
  - Minimum latency: a word pushed at edge E into an empty FIFO (FSM in IDLE, enable = 1) is popped at edge E+1. dsp_control = 5'b00001 and sample_out = that word are visible from E+1 until E+2.
  - The filter captures the word at E+2.
- sample_out holds the last issued value while dsp_control = 0.
- enable deasserted:
  - During WAIT, the wait still completes and the FSM returns to IDLE.
  - No new issue happens until enable = 1.
  - The FIFO keeps accepting words while enable = 0.
- interval changes during WAIT have no effect until the next issue.
- flush = 1 at an edge:
  - Pointers and level go to 0, the FSM goes to IDLE, pace_cnt goes to 0, dsp_control goes to 0.
  - sample_out keeps its value.
  - A concurrent push is dropped; in_ready stays as computed, and the upstream side must not count that word as accepted.
  - flush has priority over issue.
- Order is strictly FIFO. No word is duplicated or lost except by flush or reset.

Test Plan:
1. Reset, then push 0x00000010, 0x00000020, 0x00000030, 0x00000040 with enable = 1, interval = 0 -> four single-cycle 5'b00001 strobes, 2 cycles apart, carrying sample_out 0x10, 0x20, 0x30, 0x40 in order; fifo_level returns to 0 and busy drops.
2. enable = 0, push 5 words back-to-back -> the first 4 are accepted, in_ready = 0 with fifo_level = 4, the 5th is held by upstream. Set enable = 1 with interval = 3 -> strobes every 5 cycles, and the 5th word is accepted the cycle after the first pop.
3. interval = 0, continuous in_valid with fifo_level = 2 -> a push and a pop on the same edge keep fifo_level at 2. Pointer wrap over 10 words delivers all 10 in order.
4. Issue one word with interval = 10, then assert flush 3 cycles into WAIT with 2 words queued -> dsp_control = 0 next cycle, fifo_level = 0, FSM in IDLE, sample_out holds the last value, and no further strobes occur.
5. Assert reset = 0 asynchronously, mid-cycle, while dsp_control = 5'b00001 -> all outputs go to their reset values immediately (sample_out = 0, in_ready = 1). After release, pushing 0xFFFFFFFC yields one strobe with sample_out = 0xFFFFFFFC.

Source files
------------

// File: rtl/dsp_sample_feeder.sv
// Paced feeder for the 4-tap moving-average filter: buffers host samples in a
// small FIFO and issues them one at a time with a shift strobe every interval+2 cycles.
module dsp_sample_feeder #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          enable,
  input  logic [7:0]    interval,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic [DW-1:0] sample_out,
  output logic [4:0]    dsp_control,
  output logic [AW:0]   fifo_level,
  output logic          busy
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [4:0]    CTRL_SHIFT = 5'b00001;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic [7:0]    pace_cnt_q, pace_cnt_d;
  logic [DW-1:0] sample_q, sample_d;
  logic [4:0]    ctrl_q, ctrl_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic          push;
  logic          issue;

  assign in_ready = (level_q != LVL_FULL);
  assign push     = in_valid && in_ready && !flush;
  // flush outranks an issue that would otherwise happen on the same edge
  assign issue    = !flush && (state_q == S_IDLE) && enable && (level_q != '0);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (issue) state_d = S_WAIT;
        S_WAIT:  if (pace_cnt_q == '0) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output and pacing logic
  always_comb begin
    pace_cnt_d = pace_cnt_q;
    sample_d   = sample_q;
    ctrl_d     = '0;
    if (flush) begin
      pace_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (issue) begin
            sample_d   = mem_q[rd_ptr_q];
            ctrl_d     = CTRL_SHIFT;
            pace_cnt_d = interval;
          end
        end
        S_WAIT: begin
          if (pace_cnt_q != '0) pace_cnt_d = pace_cnt_q - 8'd1;
        end
        default: pace_cnt_d = '0;
      endcase
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH = 2**AW
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push)  wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (issue) rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, issue})
        2'b10:   level_d = level_q + LVL_ONE;
        2'b01:   level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      pace_cnt_q <= '0;
      sample_q   <= '0;
      ctrl_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      pace_cnt_q <= pace_cnt_d;
      sample_q   <= sample_d;
      ctrl_q     <= ctrl_d;
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are live
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  assign sample_out  = sample_q;
  assign dsp_control = ctrl_q;
  assign fifo_level  = level_q;
  assign busy        = (state_q == S_WAIT) || (level_q != '0);

endmodule
